// File: rtl/ddr3_app_responder.sv
// Behavioural DDR3 MIG user-interface responder: calibration delay, optional
// backpressure, write command/data pairing and a fixed-latency read pipeline.
module ddr3_app_responder #(
    parameter int unsigned MEM_AW       = 10,
    parameter int unsigned RD_LAT       = 8,
    parameter int unsigned CALIB_CYCLES = 64,
    parameter int unsigned STALL_PERIOD = 0
) (
    input  logic         ui_clk,
    input  logic         rst_n,
    output logic         init_calib_complete,
    input  logic [27:0]  app_addr,
    input  logic         app_en,
    input  logic [2:0]   app_cmd,
    output logic         app_rdy,
    input  logic [127:0] app_wdf_data,
    input  logic         app_wdf_wren,
    input  logic         app_wdf_end,
    output logic         app_wdf_rdy,
    output logic [127:0] app_rd_data,
    output logic         app_rd_data_valid,
    output logic         app_rd_data_end,
    output logic         err,
    output logic [31:0]  wr_cnt,
    output logic [31:0]  rd_cnt
);

    localparam int unsigned DEPTH = 1 << MEM_AW;
    // The registered read-data output is the last of the RD_LAT stages.
    localparam int unsigned NSTG  = RD_LAT - 1;

    typedef enum logic {
        CALIB = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t              state, state_nx;
    logic [15:0]         calib_cnt, calib_cnt_nx;
    logic [15:0]         stall_cnt, stall_cnt_nx;
    logic                stall_nx;
    logic                pend_cmd, pend_cmd_nx;
    logic                pend_data, pend_data_nx;
    logic [MEM_AW-1:0]   pend_idx, pend_idx_nx;
    logic [127:0]        pend_wdata, pend_wdata_nx;
    logic [NSTG-1:0]     rd_vld;
    logic [MEM_AW-1:0]   rd_idx [NSTG];
    logic [127:0]        mem [DEPTH];

    logic                cmd_acc, cmd_wr, cmd_rd, cmd_bad, data_acc, data_bad;
    logic                have_cmd, have_data, commit;
    logic [MEM_AW-1:0]   cmd_idx, wr_idx;
    logic [127:0]        wr_data;
    logic                rdy_nx, wdf_rdy_nx;
    logic                addr_unused;

    assign addr_unused = ^app_addr[27:MEM_AW+3];

    always_comb begin
        cmd_acc   = app_en & app_rdy;
        cmd_wr    = cmd_acc & (app_cmd == 3'd0);
        cmd_rd    = cmd_acc & (app_cmd == 3'd1);
        cmd_bad   = cmd_acc & ((app_cmd > 3'd1) | (app_addr[2:0] != 3'b000));
        data_acc  = app_wdf_wren & app_wdf_rdy;
        data_bad  = data_acc & ~app_wdf_end;
        cmd_idx   = app_addr[MEM_AW+2:3];

        have_cmd  = cmd_wr | pend_cmd;
        have_data = data_acc | pend_data;
        commit    = have_cmd & have_data;
        wr_idx    = pend_cmd ? pend_idx : cmd_idx;
        wr_data   = pend_data ? pend_wdata : app_wdf_data;

        pend_cmd_nx   = have_cmd & ~have_data;
        pend_data_nx  = have_data & ~have_cmd;
        pend_idx_nx   = cmd_wr ? cmd_idx : pend_idx;
        pend_wdata_nx = data_acc ? app_wdf_data : pend_wdata;

        state_nx     = state;
        calib_cnt_nx = calib_cnt;
        if (state == CALIB) begin
            if (calib_cnt + 16'd1 >= 16'(CALIB_CYCLES))
                state_nx = RUN;
            else
                calib_cnt_nx = calib_cnt + 16'd1;
        end

        if (STALL_PERIOD == 0 || stall_cnt == 16'(STALL_PERIOD - 1))
            stall_cnt_nx = '0;
        else
            stall_cnt_nx = stall_cnt + 16'd1;
        stall_nx = (STALL_PERIOD != 0) && (stall_cnt_nx == 16'(STALL_PERIOD - 1));

        // Ready flags are registered from next-cycle state so they carry no input path.
        rdy_nx     = (state_nx == RUN) & ~stall_nx & ~pend_cmd_nx;
        wdf_rdy_nx = (state_nx == RUN) & ~stall_nx & ~pend_data_nx;
    end

    always_ff @(posedge ui_clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= CALIB;
            calib_cnt           <= '0;
            stall_cnt           <= '0;
            pend_cmd            <= 1'b0;
            pend_data           <= 1'b0;
            pend_idx            <= '0;
            pend_wdata          <= '0;
            rd_vld              <= '0;
            for (int unsigned i = 0; i < NSTG; i++)
                rd_idx[i] <= '0;
            init_calib_complete <= 1'b0;
            app_rdy             <= 1'b0;
            app_wdf_rdy         <= 1'b0;
            app_rd_data         <= '0;
            app_rd_data_valid   <= 1'b0;
            app_rd_data_end     <= 1'b0;
            err                 <= 1'b0;
            wr_cnt              <= '0;
            rd_cnt              <= '0;
        end else begin
            state               <= state_nx;
            calib_cnt           <= calib_cnt_nx;
            stall_cnt           <= stall_cnt_nx;
            pend_cmd            <= pend_cmd_nx;
            pend_data           <= pend_data_nx;
            pend_idx            <= pend_idx_nx;
            pend_wdata          <= pend_wdata_nx;
            init_calib_complete <= (state_nx == RUN);
            app_rdy             <= rdy_nx;
            app_wdf_rdy         <= wdf_rdy_nx;

            rd_vld[0] <= cmd_rd;
            rd_idx[0] <= cmd_idx;
            for (int unsigned i = 1; i < NSTG; i++) begin
                rd_vld[i] <= rd_vld[i-1];
                rd_idx[i] <= rd_idx[i-1];
            end

            app_rd_data_valid <= rd_vld[NSTG-1];
            app_rd_data_end   <= rd_vld[NSTG-1];
            if (rd_vld[NSTG-1]) begin
                app_rd_data <= mem[rd_idx[NSTG-1]];
                rd_cnt      <= rd_cnt + 32'd1;
            end

            if (commit)
                wr_cnt <= wr_cnt + 32'd1;
            if (cmd_bad || data_bad)
                err <= 1'b1;
        end
    end

    // Memory array has no reset so contents survive rst_n.
    always_ff @(posedge ui_clk) begin
        if (commit)
            mem[wr_idx] <= wr_data;
    end

endmodule

// File: tb/tb_ddr3_app_responder.sv
// Directed self-checking bench for ddr3_app_responder: calibration, write/read
// paths, pending command/data, errors, reset flush and backpressure.
module tb_ddr3_app_responder;

    localparam int unsigned RD_LAT = 8;
    localparam logic [127:0] A5 = {16{8'hA5}};
    localparam logic [127:0] D0 = {4{32'h1111_0000}};
    localparam logic [127:0] D1 = {4{32'h2222_0001}};
    localparam logic [127:0] D2 = {4{32'h3333_0002}};
    localparam logic [127:0] D3 = {4{32'h4444_0003}};
    localparam logic [127:0] D4 = {4{32'h5555_0004}};
    localparam logic [127:0] D5 = {4{32'h6666_0005}};
    localparam logic [127:0] D6 = {4{32'h7777_0006}};

    logic         ui_clk = 1'b0;
    logic         rst_n  = 1'b0;

    logic         init_calib_complete;
    logic [27:0]  app_addr;
    logic         app_en;
    logic [2:0]   app_cmd;
    logic         app_rdy;
    logic [127:0] app_wdf_data;
    logic         app_wdf_wren;
    logic         app_wdf_end;
    logic         app_wdf_rdy;
    logic [127:0] app_rd_data;
    logic         app_rd_data_valid;
    logic         app_rd_data_end;
    logic         err;
    logic [31:0]  wr_cnt;
    logic [31:0]  rd_cnt;

    logic         s_init_calib_complete;
    logic [27:0]  s_app_addr;
    logic         s_app_en;
    logic [2:0]   s_app_cmd;
    logic         s_app_rdy;
    logic [127:0] s_app_wdf_data;
    logic         s_app_wdf_wren;
    logic         s_app_wdf_end;
    logic         s_app_wdf_rdy;
    logic [127:0] s_app_rd_data;
    logic         s_app_rd_data_valid;
    logic         s_app_rd_data_end;
    logic         s_err;
    logic [31:0]  s_wr_cnt;
    logic [31:0]  s_rd_cnt;

    int unsigned  n_cmp = 0;
    int unsigned  n_bad = 0;

    always #5 ui_clk = ~ui_clk;

    ddr3_app_responder #(.MEM_AW(10), .RD_LAT(RD_LAT), .CALIB_CYCLES(64), .STALL_PERIOD(0)) dut (
        .ui_clk(ui_clk), .rst_n(rst_n), .init_calib_complete(init_calib_complete),
        .app_addr(app_addr), .app_en(app_en), .app_cmd(app_cmd), .app_rdy(app_rdy),
        .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .app_rd_data_end(app_rd_data_end), .err(err), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
    );

    ddr3_app_responder #(.MEM_AW(10), .RD_LAT(RD_LAT), .CALIB_CYCLES(64), .STALL_PERIOD(4)) dut_s (
        .ui_clk(ui_clk), .rst_n(rst_n), .init_calib_complete(s_init_calib_complete),
        .app_addr(s_app_addr), .app_en(s_app_en), .app_cmd(s_app_cmd), .app_rdy(s_app_rdy),
        .app_wdf_data(s_app_wdf_data), .app_wdf_wren(s_app_wdf_wren), .app_wdf_end(s_app_wdf_end),
        .app_wdf_rdy(s_app_wdf_rdy), .app_rd_data(s_app_rd_data), .app_rd_data_valid(s_app_rd_data_valid),
        .app_rd_data_end(s_app_rd_data_end), .err(s_err), .wr_cnt(s_wr_cnt), .rd_cnt(s_rd_cnt)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        app_en       = 1'b0;
        app_cmd      = 3'd0;
        app_wdf_wren = 1'b0;
        app_wdf_end  = 1'b0;
    endtask

    task automatic wr_word(input logic [27:0] addr, input logic [127:0] data);
        check("wr_rdy", {app_rdy, app_wdf_rdy}, 2'b11);
        app_en       = 1'b1;
        app_cmd      = 3'd0;
        app_addr     = addr;
        app_wdf_wren = 1'b1;
        app_wdf_end  = 1'b1;
        app_wdf_data = data;
        @(negedge ui_clk);
        idle();
    endtask

    task automatic rd_check(input logic [27:0] addr, input logic [127:0] exp);
        int unsigned n;
        app_en       = 1'b1;
        app_cmd      = 3'd1;
        app_addr     = addr;
        app_wdf_wren = 1'b0;
        n = 0;
        do begin
            @(negedge ui_clk);
            app_en = 1'b0;
            n++;
        end while (!app_rd_data_valid && n < 40);
        check("rd_lat", n, RD_LAT);
        check("rd_data", app_rd_data, exp);
        check("rd_end", app_rd_data_end, 1'b1);
        @(negedge ui_clk);
        check("rd_pulse", app_rd_data_valid, 1'b0);
        check("rd_hold", app_rd_data, exp);
    endtask

    // Called just after rst_n is released on a negedge; done = cycles already spent.
    task automatic wait_calib(input int unsigned done);
        int unsigned pulses;
        pulses = 0;
        for (int unsigned i = done; i < 63; i++) begin
            @(negedge ui_clk);
            if (app_rd_data_valid) pulses++;
        end
        check("calib_low", {init_calib_complete, app_rdy, app_wdf_rdy}, 3'b000);
        @(negedge ui_clk);
        check("calib_high", {init_calib_complete, app_rdy, app_wdf_rdy}, 3'b111);
        check("calib_no_rd", pulses, 0);
    endtask

    initial begin
        int unsigned n;
        int unsigned zeros;
        int unsigned pulses;
        logic [7:0]  r;

        idle();
        app_addr       = '0;
        app_wdf_data   = '0;
        s_app_en       = 1'b0;
        s_app_cmd      = 3'd1;
        s_app_addr     = '0;
        s_app_wdf_data = '0;
        s_app_wdf_wren = 1'b0;
        s_app_wdf_end  = 1'b0;

        repeat (3) @(negedge ui_clk);
        check("rst_calib", init_calib_complete, 1'b0);
        check("rst_rdy", {app_rdy, app_wdf_rdy}, 2'b00);
        check("rst_valid", {app_rd_data_valid, app_rd_data_end}, 2'b00);
        check("rst_data", app_rd_data, '0);
        check("rst_err", err, 1'b0);
        check("rst_wr_cnt", wr_cnt, 0);
        check("rst_rd_cnt", rd_cnt, 0);

        // Write attempt during calibration, misaligned and without wdf_end: must be ignored.
        rst_n        = 1'b1;
        app_en       = 1'b1;
        app_cmd      = 3'd0;
        app_addr     = 28'h41;
        app_wdf_wren = 1'b1;
        app_wdf_end  = 1'b0;
        app_wdf_data = '1;
        repeat (10) @(negedge ui_clk);
        idle();
        wait_calib(10);
        check("calib_wr", wr_cnt, 0);
        check("calib_err", err, 1'b0);

        // Write and read back with fixed latency.
        wr_word(28'h40, A5);
        check("wr_cnt_1", wr_cnt, 1);
        rd_check(28'h40, A5);
        check("rd_cnt_1", rd_cnt, 1);

        // Back-to-back reads; 0x2010 aliases 0x10.
        wr_word(28'h0, D0);
        wr_word(28'h8, D1);
        wr_word(28'h2010, D2);
        check("wr_cnt_4", wr_cnt, 4);
        for (int unsigned i = 0; i < 3; i++) begin
            app_en   = 1'b1;
            app_cmd  = 3'd1;
            app_addr = 28'(i * 8);
            @(negedge ui_clk);
        end
        idle();
        n = 3;
        while (!app_rd_data_valid && n < 40) begin
            @(negedge ui_clk);
            n++;
        end
        check("b2b_lat", n, RD_LAT);
        check("b2b_d0", app_rd_data, D0);
        @(negedge ui_clk);
        check("b2b_v1", app_rd_data_valid, 1'b1);
        check("b2b_d1", app_rd_data, D1);
        @(negedge ui_clk);
        check("b2b_v2", app_rd_data_valid, 1'b1);
        check("b2b_d2", app_rd_data, D2);
        @(negedge ui_clk);
        check("b2b_v3", app_rd_data_valid, 1'b0);
        check("b2b_rd_cnt", rd_cnt, 4);

        // Command first, data three cycles later.
        app_en   = 1'b1;
        app_cmd  = 3'd0;
        app_addr = 28'h20;
        @(negedge ui_clk);
        idle();
        check("pc_rdy1", app_rdy, 1'b0);
        check("pc_wdf_rdy", app_wdf_rdy, 1'b1);
        @(negedge ui_clk);
        check("pc_rdy2", app_rdy, 1'b0);
        @(negedge ui_clk);
        check("pc_rdy3", app_rdy, 1'b0);
        check("pc_cnt_hold", wr_cnt, 4);
        app_wdf_wren = 1'b1;
        app_wdf_end  = 1'b1;
        app_wdf_data = D3;
        @(negedge ui_clk);
        idle();
        check("pc_commit", wr_cnt, 5);
        check("pc_rdy4", app_rdy, 1'b1);
        rd_check(28'h20, D3);

        // Data first, command next cycle.
        app_wdf_wren = 1'b1;
        app_wdf_end  = 1'b1;
        app_wdf_data = D4;
        @(negedge ui_clk);
        idle();
        check("pd_wdf_rdy", app_wdf_rdy, 1'b0);
        check("pd_rdy", app_rdy, 1'b1);
        check("pd_cnt_hold", wr_cnt, 5);
        app_en   = 1'b1;
        app_cmd  = 3'd0;
        app_addr = 28'h28;
        @(negedge ui_clk);
        idle();
        check("pd_commit", wr_cnt, 6);
        check("pd_wdf_rdy2", app_wdf_rdy, 1'b1);
        rd_check(28'h28, D4);
        check("rd_cnt_6", rd_cnt, 6);

        // Illegal command: err only.
        app_en   = 1'b1;
        app_cmd  = 3'd3;
        app_addr = 28'h41;
        @(negedge ui_clk);
        idle();
        check("bad_err", err, 1'b1);
        repeat (10) @(negedge ui_clk);
        check("bad_wr_cnt", wr_cnt, 6);
        check("bad_rd_cnt", rd_cnt, 6);
        rd_check(28'h40, A5);
        check("bad_err_sticky", err, 1'b1);

        // Reset with three reads in flight and a pending write command.
        for (int unsigned i = 0; i < 3; i++) begin
            app_en   = 1'b1;
            app_cmd  = 3'd1;
            app_addr = 28'(i * 8);
            @(negedge ui_clk);
        end
        app_en   = 1'b1;
        app_cmd  = 3'd0;
        app_addr = 28'h30;
        @(negedge ui_clk);
        idle();
        rst_n = 1'b0;
        #1;
        check("rst2_valid", app_rd_data_valid, 1'b0);
        check("rst2_data", app_rd_data, '0);
        check("rst2_err", err, 1'b0);
        check("rst2_cnts", {wr_cnt, rd_cnt}, 64'd0);
        check("rst2_rdy", {init_calib_complete, app_rdy, app_wdf_rdy}, 3'b000);
        repeat (2) @(negedge ui_clk);
        rst_n = 1'b1;
        wait_calib(0);

        // Pending command was discarded: lone data must wait for a command.
        app_wdf_wren = 1'b1;
        app_wdf_end  = 1'b1;
        app_wdf_data = D5;
        @(negedge ui_clk);
        idle();
        check("rst2_no_commit", wr_cnt, 0);
        check("rst2_wdf_rdy", app_wdf_rdy, 1'b0);
        app_en   = 1'b1;
        app_cmd  = 3'd0;
        app_addr = 28'h30;
        @(negedge ui_clk);
        idle();
        check("rst2_commit", wr_cnt, 1);
        rd_check(28'h30, D5);
        rd_check(28'h40, A5);
        check("rst2_rd_cnt", rd_cnt, 2);
        check("rst2_err_clean", err, 1'b0);

        // Data without wdf_end: err set, data still written.
        app_en       = 1'b1;
        app_cmd      = 3'd0;
        app_addr     = 28'h38;
        app_wdf_wren = 1'b1;
        app_wdf_end  = 1'b0;
        app_wdf_data = D6;
        @(negedge ui_clk);
        idle();
        check("end_err", err, 1'b1);
        check("end_wr_cnt", wr_cnt, 2);
        rd_check(28'h38, D6);

        // Misaligned read after a fresh reset.
        rst_n = 1'b0;
        repeat (2) @(negedge ui_clk);
        rst_n = 1'b1;
        wait_calib(0);
        check("mis_err_pre", err, 1'b0);
        rd_check(28'h44, A5);
        check("mis_err", err, 1'b1);

        // Backpressure instance: one stall every fourth cycle.
        r = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            @(negedge ui_clk);
            r[i] = s_app_rdy;
        end
        zeros = 0;
        for (int unsigned i = 0; i < 8; i++)
            if (!r[i]) zeros++;
        check("stall_zeros", zeros, 2);
        for (int unsigned i = 0; i < 4; i++)
            check("stall_period", r[i], r[i+4]);
        n = 0;
        while (s_app_rdy && n < 10) begin
            @(negedge ui_clk);
            n++;
        end
        check("stall_seen", s_app_rdy, 1'b0);
        check("stall_wdf", s_app_wdf_rdy, 1'b0);
        s_app_en   = 1'b1;
        s_app_addr = 28'h8;
        @(negedge ui_clk);
        check("stall_rdy_back", s_app_rdy, 1'b1);
        @(negedge ui_clk);
        s_app_en = 1'b0;
        pulses = 0;
        for (int unsigned i = 0; i < 16; i++) begin
            @(negedge ui_clk);
            if (s_app_rd_data_valid) pulses++;
        end
        check("stall_pulses", pulses, 1);
        check("stall_rd_cnt", s_rd_cnt, 1);
        check("stall_err", s_err, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ddr3_app_responder.md
DDR3_APP_RESPONDER -- requirements
Module: ddr3_app_responder

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- MEM_AW, 10, log2 of memory depth in 128-bit words
- RD_LAT, 8, read latency in ui_clk cycles, from command accept to app_rd_data_valid; legal range 2..32
- CALIB_CYCLES, 64, cycles after reset before calibration completes
- STALL_PERIOD, 0, backpressure period; 0 disables stalls

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- ui_clk, in, 1, clock
- rst_n, in, 1, reset
- init_calib_complete, out, 1, calibration done
- app_addr, in, 28, command address
- app_en, in, 1, command valid
- app_cmd, in, 3, command: 0 = write, 1 = read
- app_rdy, out, 1, command accept
- app_wdf_data, in, 128, write data
- app_wdf_wren, in, 1, write data valid
- app_wdf_end, in, 1, last beat of write data
- app_wdf_rdy, out, 1, write data accept
- app_rd_data, out, 128, read data
- app_rd_data_valid, out, 1, read data valid
- app_rd_data_end, out, 1, last beat of read data
- err, out, 1, sticky protocol error
- wr_cnt, out, 32, writes committed
- rd_cnt, out, 32, reads returned

REQ-003 Reset SHALL be rst_n, asynchronous, active-low; the clock SHALL be ui_clk.

Function
REQ-004 The state machine SHALL have two states, CALIB and RUN. Reset SHALL enter CALIB. A 16-bit counter SHALL move the block to RUN after CALIB_CYCLES cycles. RUN SHALL hold until reset.
REQ-005 init_calib_complete SHALL be 1 only in RUN. app_rdy and app_wdf_rdy SHALL be 0 in CALIB.
REQ-006 Stall cycles: a free-running counter SHALL count modulo STALL_PERIOD. When STALL_PERIOD != 0 and the counter equals STALL_PERIOD-1, app_rdy and app_wdf_rdy SHALL both be 0 for that cycle.
REQ-007 A command SHALL be accepted on a cycle where app_en and app_rdy are both 1.
REQ-007a Write data SHALL be accepted on a cycle where app_wdf_wren and app_wdf_rdy are both 1.
REQ-008 The word index SHALL be app_addr[MEM_AW+2:3]. Higher address bits SHALL be ignored, so addresses alias.
REQ-008a A nonzero app_addr[2:0] on an accepted command SHALL set err.
REQ-009 A write SHALL commit to memory in the cycle both of these are present: the write command (accepted now or pending) and the data (accepted now or pending). wr_cnt SHALL increment by 1 per commit.
REQ-010 If a write command is accepted without data, a one-deep pending-command register SHALL hold it. app_rdy SHALL be 0 until the data arrives. Pending data SHALL be handled symmetrically: app_wdf_rdy SHALL be 0 until the command arrives.
REQ-011 Accepted data with app_wdf_end = 0 SHALL set err. The data SHALL still be used.
REQ-012 Each accepted read SHALL enter an RD_LAT-stage valid/index shift pipeline; one read SHALL be accepted per cycle at most, with no stall required.
REQ-012a Memory SHALL be read at the final stage. app_rd_data_valid and app_rd_data_end SHALL both pulse 1 for one cycle exactly RD_LAT cycles after accept, in command order. rd_cnt SHALL increment on each pulse.
REQ-013 Read-after-write: a read accepted in the cycle after the write commit, or later, SHALL return the new data.
REQ-013a A read and a write to the same index accepted in the same cycle cannot occur, because there is a single command port.
REQ-014 An accepted command with app_cmd other than 0 or 1 SHALL set err and SHALL have no other effect.
REQ-015 app_wdf_wren while app_wdf_rdy = 0 SHALL be ignored and SHALL NOT set err.
REQ-016 wr_cnt and rd_cnt SHALL wrap modulo 2^32.
REQ-016a app_rd_data SHALL hold its last value when app_rd_data_valid = 0.

Reset
REQ-017 On reset assertion, the following SHALL apply immediately:
- state = CALIB
- all outputs = 0 (app_rd_data = 0)
- pending registers cleared
- read pipeline flushed, so no valid is emitted for reads in flight
- err, wr_cnt and rd_cnt cleared
REQ-018 Memory contents SHALL NOT be cleared by reset.
REQ-019 Reset mid-write SHALL discard any uncommitted pending command or data.

Verification
REQ-020 After reset release, init_calib_complete and app_rdy stay 0 for 64 cycles, then go 1; a write attempted during CALIB is not accepted.
REQ-021 Write 0xA5...A5 to addr 0x40 with app_en, app_cmd = 0 and app_wdf_wren in the same cycle, then read 0x40 on the next cycle -> app_rd_data_valid pulses exactly 8 cycles after the read accept with data 0xA5...A5; wr_cnt = 1 and rd_cnt = 1.
REQ-022 Back-to-back reads of 0x0, 0x8 and 0x10 on three consecutive cycles -> three consecutive valid pulses, in order, with the previously written data.
REQ-023 Write command at cycle t and data at t+3 -> app_rdy is 0 for t+1..t+3, the commit happens at t+3, and wr_cnt increments once.
REQ-024 STALL_PERIOD = 4 -> app_rdy is 0 on every 4th cycle; a held app_en is accepted on the next ready cycle and no command is duplicated.
REQ-025 app_cmd = 3, addr 0x41 -> err = 1; memory is unchanged; rd_cnt and wr_cnt are unchanged. Reset asserted with 3 reads in flight -> no app_rd_data_valid pulse afterwards.
